div_op_sequencer: RTL

//  Upstream issuer and downstream collector wrapped around the single-precision divider.

---
 rtl/div_seq_pkg.sv | 35 +++
 rtl/div_pair_fifo.sv | 69 ++++++
 rtl/div_op_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_pkg
//  Description : Shared types and constants for the divider op sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_seq_pkg;

    // IEEE-754 single-precision word width
    localparam int FP_W      = 32;
    // Width of the optional per-op latency counter
    localparam int LAT_W     = 16;
    // Default request tag width
    localparam int TAG_W_DEF = 4;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND_A = 3'd1,
        S_SEND_B = 3'd2,
        S_WAIT_Z = 3'd3,
        S_ACK_Z  = 3'd4,
        S_OUT    = 3'd5
    } seq_state_t;

    // Operand pair layout at the default tag width; the top re-declares the
    // same layout sized by its own TAG_W parameter.
    typedef struct packed {
        logic [FP_W-1:0]      a;
        logic [FP_W-1:0]      b;
        logic [TAG_W_DEF-1:0] tag;
    } div_pair_t;

endpackage
`default_nettype wire

// File: rtl/div_pair_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : div_pair_fifo
//  Description : Synchronous FIFO holding tagged operand pairs. Power-of-two
//                depth, pointers wrap naturally, no full pass-through.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_LVL_W = c_AW + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_level == c_LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage write; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : div_op_sequencer
//  Description : Buffers tagged operand pairs, feeds them one at a time to a
//                serial-handshake single-precision divider and returns each
//                quotient with its tag on a valid/ready result port.
//                Optional macro DIV_SEQ_LATENCY_EN adds a per-op latency
//                counter reported on res_latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_op_sequencer
    import div_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FP_W-1:0]        req_a,
    input  logic [FP_W-1:0]        req_b,
    input  logic [TAG_W-1:0]       req_tag,
    input  logic                   req_valid,
    output logic                   req_ready,
    output logic [FP_W-1:0]        input_a,
    output logic [FP_W-1:0]        input_b,
    output logic                   input_a_stb,
    output logic                   input_b_stb,
    input  logic                   input_a_ack,
    input  logic                   input_b_ack,
    input  logic [FP_W-1:0]        output_z,
    input  logic                   output_z_stb,
    output logic                   output_z_ack,
    output logic [FP_W-1:0]        res_z,
    output logic [TAG_W-1:0]       res_tag,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
`ifdef DIV_SEQ_LATENCY_EN
    ,
    output logic [LAT_W-1:0]       res_latency
`endif
);

    typedef struct packed {
        logic [FP_W-1:0]  a;
        logic [FP_W-1:0]  b;
        logic [TAG_W-1:0] tag;
    } pair_t;

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    pair_t            w_fifo_din;
    pair_t            w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_a_xfer;
    logic             w_b_xfer;
    logic [TAG_W-1:0] r_op_tag;

    assign req_ready  = !w_full;
    assign w_push     = req_valid && req_ready;
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_a_xfer   = input_a_stb && input_a_ack;
    assign w_b_xfer   = input_b_stb && input_b_ack;
    assign busy       = (r_state != S_IDLE);
    assign w_fifo_din = '{a: req_a, b: req_b, tag: req_tag};

    div_pair_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(pair_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; one op in flight, result must be taken before the next pop
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty)    w_state_next = S_SEND_A;
            S_SEND_A: if (w_a_xfer)    w_state_next = S_SEND_B;
            S_SEND_B: if (w_b_xfer)    w_state_next = S_WAIT_Z;
            S_WAIT_Z: if (output_z_stb) w_state_next = S_ACK_Z;
            S_ACK_Z:                   w_state_next = S_OUT;
            S_OUT:    if (res_ready)   w_state_next = S_IDLE;
            default:                   w_state_next = S_IDLE;
        endcase
    end

    // Registered divider handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            input_a      <= '0;
            input_b      <= '0;
            input_a_stb  <= 1'b0;
            input_b_stb  <= 1'b0;
            output_z_ack <= 1'b0;
            res_z        <= '0;
            res_tag      <= '0;
            res_valid    <= 1'b0;
            r_op_tag     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        input_a     <= w_head.a;
                        input_b     <= w_head.b;
                        r_op_tag    <= w_head.tag;
                        input_a_stb <= 1'b1;
                    end
                end
                S_SEND_A: begin
                    if (w_a_xfer) begin
                        input_a_stb <= 1'b0;
                        input_b_stb <= 1'b1;
                    end
                end
                S_SEND_B: begin
                    if (w_b_xfer) begin
                        input_b_stb <= 1'b0;
                    end
                end
                S_WAIT_Z: begin
                    if (output_z_stb) begin
                        res_z        <= output_z;
                        res_tag      <= r_op_tag;
                        output_z_ack <= 1'b1;
                    end
                end
                S_ACK_Z: begin
                    // Divider sees stb && ack during this cycle; release ack after it
                    output_z_ack <= 1'b0;
                    res_valid    <= 1'b1;
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_SEQ_LATENCY_EN
    logic [LAT_W-1:0] r_lat_cnt;

    // Saturating cycle count from op launch until the quotient strobe is seen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_cnt   <= '0;
            res_latency <= '0;
        end else begin
            if (w_pop) begin
                r_lat_cnt <= '0;
            end else if ((r_state == S_SEND_A || r_state == S_SEND_B ||
                          (r_state == S_WAIT_Z && !output_z_stb)) &&
                         (r_lat_cnt != {LAT_W{1'b1}})) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end
            if (r_state == S_WAIT_Z && output_z_stb) begin
                res_latency <= r_lat_cnt;
            end
        end
    end
`endif

endmodule
`default_nettype wire
